// File: rtl/division_sub_pkg.sv
// division_sub_pkg: shared FSM state encoding and default operand width for the repeated-subtraction divider.
// Contents:
//   WIDTH_DEF - default operand/quotient/remainder width
//   state_t   - control FSM states (IDLE, LOAD_D, RUN, DONE)
package division_sub_pkg;
  localparam int WIDTH_DEF = 15;
  typedef enum logic [1:0] {IDLE, LOAD_D, RUN, DONE} state_t;
endpackage

// File: rtl/division_sub_subtractor.sv
// subtractor: combinational a-b with an unsigned a>=b flag, the divider's datapath ALU.
// Ports:
//   a, b  - unsigned WIDTH-bit operands
//   diff  - a - b (only meaningful when ge=1)
//   ge    - 1 when a >= b (unsigned)
module subtractor #(
  parameter int WIDTH = 15
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             ge
);
  assign diff = a - b;
  assign ge   = a >= b;
endmodule

// File: rtl/division_sub.sv
// division_sub: sequential unsigned divider by repeated subtraction with a registered datapath and two-process FSM.
// Ports:
//   clk       - rising-edge clock
//   rst       - asynchronous active-low reset
//   start     - request, accepted only while ready=1
//   data_in   - dividend on the accept edge, divisor on the following edge
//   ready     - high in IDLE
//   done      - one-cycle result-valid pulse
//   quotient  - registered quotient
//   remainder - registered remainder
//   div_zero  - registered divide-by-zero flag
module division_sub
  import division_sub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);
  state_t           state, state_nx;
  logic [WIDTH-1:0] r, d, q, diff;
  logic             ge, dz;
  logic             load_r, clr, load_d, dec, set_dz;

  subtractor #(.WIDTH(WIDTH)) u_sub (
    .a   (r),
    .b   (d),
    .diff(diff),
    .ge  (ge)
  );

  // Control: strobes for the R/D/Q registers; clr and load_r fire together on accept.
  always_comb begin
    state_nx = state;
    load_r   = 1'b0;
    clr      = 1'b0;
    load_d   = 1'b0;
    dec      = 1'b0;
    set_dz   = 1'b0;
    case (state)
      IDLE: begin
        load_r   = start;
        clr      = start;
        state_nx = start ? LOAD_D : IDLE;
      end
      LOAD_D: begin
        load_d   = 1'b1;
        set_dz   = data_in == '0;
        state_nx = (data_in == '0) ? DONE : RUN;
      end
      RUN: begin
        dec      = ge;
        state_nx = ge ? RUN : DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      r     <= '0;
      d     <= '0;
      q     <= '0;
      dz    <= 1'b0;
    end else begin
      state <= state_nx;
      if (load_r) r <= data_in;
      else if (dec) r <= diff;
      if (clr) q <= '0;
      else if (dec) q <= q + 1'b1;
      if (load_d) d <= data_in;
      if (clr) dz <= 1'b0;
      else if (set_dz) dz <= 1'b1;
    end
  end

  assign ready     = state == IDLE;
  assign done      = state == DONE;
  assign quotient  = q;
  assign remainder = r;
  assign div_zero  = dz;
endmodule

// File: tb/tb_division_sub.sv
// tb_division_sub: randomized and directed self-checking bench for division_sub against an arithmetic reference.
module tb_division_sub;
  localparam int W = 15;
  logic         clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [W-1:0] data_in = '0;
  logic         ready, done, div_zero;
  logic [W-1:0] quotient, remainder;
  int n_checks = 0, n_fail = 0;

  division_sub #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in),
    .ready(ready), .done(done), .quotient(quotient),
    .remainder(remainder), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  // Reference model: plain integer division, zero divisor keeps the dividend.
  function automatic void model(input int a, input int b, output int eq, output int er, output bit ez, output int lat);
    ez  = (b == 0);
    eq  = ez ? 0 : a / b;
    er  = ez ? a : a % b;
    lat = ez ? 2 : eq + 3;
  endfunction

  // Starts at a negedge with ready=1; returns edges counted from (and including) the accept edge up to done.
  task automatic run_op(input int a, input int b, input bit noise, input int limit, output int edges, output bit timeout);
    start   = 1'b1;
    data_in = W'(a);
    @(negedge clk);
    start   = 1'b0;
    data_in = W'(b);
    edges   = 1;
    while (!done && edges < limit) begin
      @(negedge clk);
      edges++;
      if (!done && noise) begin
        start   = 1'($urandom);
        data_in = W'($urandom);
      end
    end
    timeout = !done;
    start   = 1'b0;
  endtask

  task automatic test_reset;
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({ready, done, div_zero, quotient, remainder} !== {1'b1, 1'b0, 1'b0, 15'd0, 15'd0}) begin
      n_fail++;
      $display("FAIL reset: ready=%b done=%b dz=%b q=%0d r=%0d want 1 0 0 0 0", ready, done, div_zero, quotient, remainder);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed;
    int ta[4] = '{100, 5, 9, 32767};
    int tb[4] = '{7, 9, 0, 1};
    int eq, er, lat, edges;
    bit ez, to;
    for (int i = 0; i < 4; i++) begin
      model(ta[i], tb[i], eq, er, ez, lat);
      run_op(ta[i], tb[i], 1'b0, lat + 50, edges, to);
      n_checks++;
      if (to || edges != lat) begin n_fail++; $display("FAIL directed_latency %0d/%0d: edges=%0d timeout=%b want %0d", ta[i], tb[i], edges, to, lat); end
      n_checks++;
      if (quotient !== W'(eq) || remainder !== W'(er) || div_zero !== ez) begin
        n_fail++;
        $display("FAIL directed_result %0d/%0d: q=%0d r=%0d dz=%b want %0d %0d %b", ta[i], tb[i], quotient, remainder, div_zero, eq, er, ez);
      end
      n_checks++;
      if (ready !== 1'b0) begin n_fail++; $display("FAIL directed_ready_in_done: ready=%b want 0", ready); end
      @(negedge clk);
      n_checks++;
      if (ready !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL directed_ready_after: ready=%b done=%b want 1 0", ready, done); end
      repeat (3) @(negedge clk);
      n_checks++;
      if (quotient !== W'(eq) || remainder !== W'(er) || div_zero !== ez || done !== 1'b0) begin
        n_fail++;
        $display("FAIL directed_hold %0d/%0d: q=%0d r=%0d dz=%b done=%b want %0d %0d %b 0", ta[i], tb[i], quotient, remainder, div_zero, done, eq, er, ez);
      end
    end
  endtask

  task automatic test_back_to_back;
    int edges;
    bit to;
    run_op(50, 5, 1'b1, 200, edges, to);
    n_checks++;
    if (to || edges != 13 || quotient !== 15'd10 || remainder !== 15'd0 || div_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_50_5: edges=%0d to=%b q=%0d r=%0d dz=%b want 13 0 10 0 0", edges, to, quotient, remainder, div_zero);
    end
    @(negedge clk);
    n_checks++;
    if (ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: ready=%b want 1", ready); end
    run_op(12, 4, 1'b0, 100, edges, to);
    n_checks++;
    if (to || edges != 6 || quotient !== 15'd3 || remainder !== 15'd0 || div_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_12_4: edges=%0d to=%b q=%0d r=%0d dz=%b want 6 0 3 0 0", edges, to, quotient, remainder, div_zero);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int edges;
    bit to, seen_done;
    start   = 1'b1;
    data_in = 15'd1000;
    @(negedge clk);
    start   = 1'b0;
    data_in = 15'd3;
    repeat (20) @(negedge clk);
    n_checks++;
    if (ready !== 1'b0) begin n_fail++; $display("FAIL mid_busy: ready=%b want 0", ready); end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({ready, done, div_zero, quotient, remainder} !== {1'b1, 1'b0, 1'b0, 15'd0, 15'd0}) begin
      n_fail++;
      $display("FAIL mid_reset: ready=%b done=%b dz=%b q=%0d r=%0d want 1 0 0 0 0", ready, done, div_zero, quotient, remainder);
    end
    seen_done = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen_done |= done;
    end
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      seen_done |= done;
    end
    n_checks++;
    if (seen_done || ready !== 1'b1) begin n_fail++; $display("FAIL mid_no_done: done_seen=%b ready=%b want 0 1", seen_done, ready); end
    run_op(7, 2, 1'b0, 100, edges, to);
    n_checks++;
    if (to || edges != 6 || quotient !== 15'd3 || remainder !== 15'd1 || div_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL after_reset_7_2: edges=%0d to=%b q=%0d r=%0d dz=%b want 6 0 3 1 0", edges, to, quotient, remainder, div_zero);
    end
    @(negedge clk);
  endtask

  task automatic test_random;
    int a, b, eq, er, lat, edges;
    bit ez, to;
    for (int i = 0; i < 12; i++) begin
      a = int'($urandom_range(0, 32767));
      b = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(40, 32767));
      model(a, b, eq, er, ez, lat);
      run_op(a, b, 1'($urandom), lat + 50, edges, to);
      n_checks++;
      if (to || edges != lat || quotient !== W'(eq) || remainder !== W'(er) || div_zero !== ez) begin
        n_fail++;
        $display("FAIL random %0d/%0d: edges=%0d to=%b q=%0d r=%0d dz=%b want %0d 0 %0d %0d %b", a, b, edges, to, quotient, remainder, div_zero, lat, eq, er, ez);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
